// File: rtl/memory_controller_if.sv
// Request/return bundle for memory_controller: one write port and one read port,
// each with a registered return channel carrying the full request address.
interface memory_controller_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] wr_address;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] wr_ret_address;
    logic              wr_ret_ack;
    logic [ADDR_W-1:0] rd_address;
    logic              rd_en;
    logic [DATA_W-1:0] rd_ret_data;
    logic [ADDR_W-1:0] rd_ret_address;
    logic              rd_ret_ack;

    modport master (
        output wr_address, wr_en, wr_data, rd_address, rd_en,
        input  wr_ret_address, wr_ret_ack, rd_ret_data, rd_ret_address, rd_ret_ack
    );

    modport slave (
        input  wr_address, wr_en, wr_data, rd_address, rd_en,
        output wr_ret_address, wr_ret_ack, rd_ret_data, rd_ret_address, rd_ret_ack
    );
endinterface

// File: rtl/memory_controller.sv
// Two-stage pipelined single-array memory with independent write and read ports,
// fixed two-edge latency, and same-stage write-to-read forwarding.
module memory_controller #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int MEM_AW = 12
) (
    input  logic                clk,
    input  logic                reset,
    memory_controller_if.slave  bus
);
    localparam int DEPTH = 2 ** MEM_AW;

    // Contents power up as zero and are deliberately left out of the reset domain.
    logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

    logic              s1_wr_valid;
    logic [ADDR_W-1:0] s1_wr_addr;
    logic [DATA_W-1:0] s1_wr_data;
    logic              s1_rd_valid;
    logic [ADDR_W-1:0] s1_rd_addr;

    logic [MEM_AW-1:0] s1_wr_idx;
    logic [MEM_AW-1:0] s1_rd_idx;
    logic [DATA_W-1:0] rd_word;

    assign s1_wr_idx = s1_wr_addr[MEM_AW-1:0];
    assign s1_rd_idx = s1_rd_addr[MEM_AW-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_wr_valid <= 1'b0;
            s1_wr_addr  <= '0;
            s1_wr_data  <= '0;
            s1_rd_valid <= 1'b0;
            s1_rd_addr  <= '0;
        end else begin
            s1_wr_valid <= bus.wr_en;
            s1_wr_addr  <= bus.wr_address;
            s1_wr_data  <= bus.wr_data;
            s1_rd_valid <= bus.rd_en;
            s1_rd_addr  <= bus.rd_address;
        end
    end

    always_ff @(posedge clk) begin
        if (s1_wr_valid) begin
            mem[s1_wr_idx] <= s1_wr_data;
        end
    end

    // A write sitting in the same stage lands on this edge, so the read must see it.
    always_comb begin
        rd_word = mem[s1_rd_idx];
        if (s1_wr_valid && (s1_wr_idx == s1_rd_idx)) begin
            rd_word = s1_wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.wr_ret_ack     <= 1'b0;
            bus.wr_ret_address <= '0;
            bus.rd_ret_ack     <= 1'b0;
            bus.rd_ret_address <= '0;
            bus.rd_ret_data    <= '0;
        end else begin
            bus.wr_ret_ack <= s1_wr_valid;
            bus.rd_ret_ack <= s1_rd_valid;
            if (s1_wr_valid) begin
                bus.wr_ret_address <= s1_wr_addr;
            end
            if (s1_rd_valid) begin
                bus.rd_ret_address <= s1_rd_addr;
                bus.rd_ret_data    <= rd_word;
            end
        end
    end
endmodule

// File: tb/tb_memory_controller.sv
// Self-checking bench for memory_controller: directed scenarios plus randomized
// traffic compared against a word-array reference model.
module tb_memory_controller;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    localparam int MEM_AW = 12;

    logic clk = 1'b0;
    logic reset;
    int   tests_run = 0;
    int   tests_failed = 0;

    memory_controller_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    memory_controller #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_AW(MEM_AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference memory: a plain word array indexed by the low address bits.
    logic [DATA_W-1:0] model_mem [2**MEM_AW];

    logic              pend_wr_v, cur_wr_v;
    logic [ADDR_W-1:0] pend_wr_a, cur_wr_a;
    logic              pend_rd_v, cur_rd_v;
    logic [ADDR_W-1:0] pend_rd_a, cur_rd_a;
    logic [DATA_W-1:0] pend_rd_d, cur_rd_d;
    logic [ADDR_W-1:0] hold_wr_a;
    logic [ADDR_W-1:0] hold_rd_a;
    logic [DATA_W-1:0] hold_rd_d;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic clearExpectations();
        pend_wr_v = 1'b0; pend_wr_a = '0;
        pend_rd_v = 1'b0; pend_rd_a = '0; pend_rd_d = '0;
        hold_wr_a = '0; hold_rd_a = '0; hold_rd_d = '0;
    endtask

    // Called at a negedge; drives one request cycle, then checks the returns that
    // belong to the request sampled one edge earlier.
    task automatic applyStimulus(input logic we, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                                 input logic re, input logic [ADDR_W-1:0] ra);
        bus.wr_en = we; bus.wr_address = wa; bus.wr_data = wd;
        bus.rd_en = re; bus.rd_address = ra;
        @(posedge clk);
        if (we) model_mem[wa[MEM_AW-1:0]] = wd;
        cur_wr_v = we; cur_wr_a = wa;
        cur_rd_v = re; cur_rd_a = ra;
        cur_rd_d = re ? model_mem[ra[MEM_AW-1:0]] : '0;
        @(negedge clk);
        if (pend_wr_v) hold_wr_a = pend_wr_a;
        if (pend_rd_v) begin
            hold_rd_a = pend_rd_a;
            hold_rd_d = pend_rd_d;
        end
        checkOutput("wr_ret_ack", 32'(bus.wr_ret_ack), 32'(pend_wr_v));
        checkOutput("wr_ret_address", 32'(bus.wr_ret_address), 32'(hold_wr_a));
        checkOutput("rd_ret_ack", 32'(bus.rd_ret_ack), 32'(pend_rd_v));
        checkOutput("rd_ret_address", 32'(bus.rd_ret_address), 32'(hold_rd_a));
        checkOutput("rd_ret_data", 32'(bus.rd_ret_data), 32'(hold_rd_d));
        pend_wr_v = cur_wr_v; pend_wr_a = cur_wr_a;
        pend_rd_v = cur_rd_v; pend_rd_a = cur_rd_a; pend_rd_d = cur_rd_d;
    endtask

    task automatic checkResetOutputs(input string phase);
        checkOutput({phase, "_wr_ret_ack"}, 32'(bus.wr_ret_ack), 32'd0);
        checkOutput({phase, "_wr_ret_address"}, 32'(bus.wr_ret_address), 32'd0);
        checkOutput({phase, "_rd_ret_ack"}, 32'(bus.rd_ret_ack), 32'd0);
        checkOutput({phase, "_rd_ret_address"}, 32'(bus.rd_ret_address), 32'd0);
        checkOutput({phase, "_rd_ret_data"}, 32'(bus.rd_ret_data), 32'd0);
    endtask

    initial begin
        logic              we, re;
        logic [ADDR_W-1:0] wa, ra;
        logic [DATA_W-1:0] wd;

        for (int i = 0; i < 2**MEM_AW; i++) model_mem[i] = '0;
        clearExpectations();
        reset = 1'b1;
        bus.wr_en = 1'b0; bus.wr_address = '0; bus.wr_data = '0;
        bus.rd_en = 1'b0; bus.rd_address = '0;

        #1;
        checkResetOutputs("por");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Read of untouched storage returns zero.
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0005);
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);

        // Write then read back the same word.
        applyStimulus(1'b1, 16'h0003, 16'h00A5, 1'b0, 16'h0000);
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0003);
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);

        // Streaming writes and reads to the same addresses on the same edges.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, ADDR_W'(i), DATA_W'(i), 1'b1, ADDR_W'(i));
        end
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);

        // Upper address bits alias onto the same word but are returned intact.
        applyStimulus(1'b1, 16'h1003, 16'h1234, 1'b0, 16'h0000);
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0003);
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);

        // Random traffic over a few aliased low indices to hit forwarding often.
        for (int i = 0; i < 300; i++) begin
            we = ($urandom_range(0, 3) != 0);
            re = ($urandom_range(0, 3) != 0);
            wa = ADDR_W'(($urandom & 32'hF000) | $urandom_range(0, 7));
            ra = ADDR_W'(($urandom & 32'hF000) | $urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) wa = ADDR_W'($urandom);
            if ($urandom_range(0, 9) == 0) ra = ADDR_W'($urandom);
            wd = DATA_W'($urandom);
            applyStimulus(we, wa, wd, re, ra);
        end

        // Reset with a read in flight: outputs clear at once, the read never returns.
        applyStimulus(1'b1, 16'h0004, 16'hBEEF, 1'b0, 16'h0000);
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0004);
        #2;
        reset = 1'b1;
        #1;
        checkResetOutputs("midrst");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        clearExpectations();
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);

        // Storage survives reset.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b1, ADDR_W'(i));
        end
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/memory_controller.md
MEMORY_CONTROLLER -- requirements
Module: memory_controller

Interface
REQ-001 The block SHALL take parameter DATA_W, default 16, as the data width of all data ports.
REQ-002 The block SHALL take parameter ADDR_W, default 16, as the address width of all address ports.
REQ-003 The block SHALL take parameter MEM_AW, default 12, giving storage depth 2**MEM_AW words; MEM_AW SHALL be <= ADDR_W.
REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port wr_address, input, ADDR_W: write request address.
REQ-007 Port wr_en, input, 1: write request valid, sampled every rising edge.
REQ-008 Port wr_data, input, DATA_W: write request data.
REQ-009 Port wr_ret_address, output, ADDR_W: address of the completing write.
REQ-010 Port wr_ret_ack, output, 1: one-cycle pulse per completed write.
REQ-011 Port rd_address, input, ADDR_W: read request address.
REQ-012 Port rd_en, input, 1: read request valid, sampled every rising edge.
REQ-013 Port rd_ret_data, output, DATA_W: data of the completing read.
REQ-014 Port rd_ret_address, output, ADDR_W: address of the completing read.
REQ-015 Port rd_ret_ack, output, 1: one-cycle pulse per completed read.

Function
REQ-016 The block SHALL hold one 2**MEM_AW x DATA_W storage array, indexed by address[MEM_AW-1:0]; upper address bits SHALL be ignored for indexing.
REQ-017 The block SHALL accept one write and one read request on every edge where the respective enable is 1; there is no backpressure and no request SHALL be dropped.
REQ-018 Pipeline: edge N samples request into stage-1 registers; edge N+1 performs the array write or array read; ret outputs and ack SHALL be registered and valid after edge N+1, i.e. ack high for exactly the cycle between edges N+1 and N+2 (fixed latency 2 edges).
REQ-019 Returned addresses SHALL equal the full ADDR_W request address, including ignored upper bits.
REQ-020 Acks SHALL be asserted for exactly one cycle per request; back-to-back requests SHALL produce back-to-back acks in request order.
REQ-021 A read SHALL return the array contents including any write sampled on the same or any earlier edge (write-before-read forwarding when indices match in the same stage).
REQ-022 Cycles with enable 0 SHALL produce ack 0; ret_address and ret_data SHALL hold their last values when ack is 0.
REQ-023 Write and read paths SHALL be independent; a write with wr_en 0 SHALL not modify the array.
REQ-024 Storage contents SHALL be zero at power-up (initialization) and SHALL NOT be cleared by reset.

Reset
REQ-025 While reset is 1, wr_ret_ack, rd_ret_ack SHALL be 0 and wr_ret_address, rd_ret_address, rd_ret_data SHALL be 0, asynchronously.
REQ-026 Reset SHALL discard all in-flight pipeline requests; no ack for a request sampled before or during reset SHALL appear after release.
REQ-027 The first request SHALL be sampled on the first rising edge with reset 0.

Verification
REQ-028 Power-up, rd_en=1 rd_address=0x0005 one cycle -> rd_ret_ack pulse 2 edges later, rd_ret_data=0x0000, rd_ret_address=0x0005.
REQ-029 Write 0x00A5 to 0x0003, then read 0x0003 -> rd_ret_data=0x00A5, wr_ret_address=0x0003 with wr_ret_ack pulse.
REQ-030 Streaming: wr_en=rd_en=1 for 5 edges, wr_address=rd_address=wr_data=0,1,2,3,4 -> five consecutive rd_ret_ack cycles returning (addr,data) = (0,0),(1,1),(2,2),(3,3),(4,4).
REQ-031 Aliasing: write 0x1234 to 0x1003, read 0x0003 -> rd_ret_data=0x1234, rd_ret_address=0x0003.
REQ-032 Assert reset with a read in flight -> outputs 0 immediately, no ack after release; array contents retained on subsequent read.
